// File: rtl/mpu_check_arbiter_pkg.sv
// ============================================================================
// Module      : mpu_check_arbiter_pkg
// Description : Shared types and constants for the MPU check arbiter slice.
//               Holds the core-id and address widths, the access_check
//               result encoding, the arbiter state encoding and the default
//               watchdog length.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mpu_check_arbiter_pkg;

    localparam int CORE_ID_WIDTH   = 2;
    localparam int ADDR_WIDTH      = 32;

    // Default watchdog length, in WAIT cycles, before a check is force-denied.
    localparam int MPU_ARB_TIMEOUT = 16;

    // Result returned by access_check. DENIED is the all-zero code so that a
    // cleared or forced response is always a safe refusal.
    typedef enum logic [1:0] {
        ACCESS_DENIED     = 2'd0,
        ACCESS_GRANTED    = 2'd1,
        ACCESS_GRANTED_RO = 2'd2,
        ACCESS_FAULT      = 2'd3
    } access_check_result_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

endpackage : mpu_check_arbiter_pkg

`default_nettype wire

// File: rtl/mpu_check_arbiter_rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin picker. Scans the request vector
//               upward starting one position above last_grant, wrapping
//               modulo N, and returns the first set bit both as a one-hot
//               vector and as an index. With no request the grant is zero.
// Ports       : req        in  [N-1:0]      request vector
//               last_grant in  [IDX_W-1:0]  index of the previous winner
//               grant      out [N-1:0]      one-hot winner (zero if none)
//               grant_idx  out [IDX_W-1:0]  winner index (zero if none)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    int   w_idx;
    logic w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        // Offset 1..N visits every requester exactly once, the previous
        // winner last, which gives the round-robin fairness.
        for (int off = 1; off <= N; off++) begin
            w_idx = (int'(last_grant) + off) % N;
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                grant[w_idx] = 1'b1;
                grant_idx    = IDX_W'(w_idx);
            end
        end
    end

endmodule : rr_picker

`default_nettype wire

// File: rtl/mpu_check_arbiter.sv
// ============================================================================
// Module      : mpu_check_arbiter
// Description : Shares one access_check instance among NUM_CORES requesters.
//               A round-robin winner is latched onto the chk_* bus, a single
//               chk_cs pulse starts the check, and the result is returned as
//               a one-cycle strobe on the winner's resp_valid bit. A watchdog
//               force-denies checks that do not finish in TIMEOUT_CYCLES.
// Ports       : clk, rst             clock, synchronous active-high reset
//               req/req_addr/req_we  per-core request level, address, write
//               resp_valid           one-hot response strobe
//               resp_result          result, valid with resp_valid
//               resp_timeout         response was forced by the watchdog
//               chk_cs               one-cycle start pulse to access_check
//               chk_core_id/addr/we  latched winner, stable until response
//               chk_result/rdy/bsy   access_check result, strobe, busy
//               busy                 arbiter not idle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mpu_check_arbiter
    import mpu_check_arbiter_pkg::*;
#(
    parameter int NUM_CORES      = 4,
    parameter int TIMEOUT_CYCLES = MPU_ARB_TIMEOUT
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_CORES-1:0]                 req,
    input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CORES-1:0]                 req_we,
    output logic [NUM_CORES-1:0]                 resp_valid,
    output access_check_result_t                 resp_result,
    output logic                                 resp_timeout,
    output logic                                 chk_cs,
    output logic [CORE_ID_WIDTH-1:0]             chk_core_id,
    output logic [ADDR_WIDTH-1:0]                chk_addr,
    output logic                                 chk_we,
    input  access_check_result_t                 chk_result,
    input  logic                                 chk_rdy,
    input  logic                                 chk_bsy,
    output logic                                 busy
);

    localparam int                  c_WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_WD_W-1:0]   c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CORE_ID_WIDTH-1:0] c_LAST_INIT = CORE_ID_WIDTH'(NUM_CORES - 1);

    arb_state_t                 r_state;
    logic [CORE_ID_WIDTH-1:0]   r_last_grant;
    logic [c_WD_W-1:0]          r_wd_cnt;
    logic [NUM_CORES-1:0]       r_grant_oh;

    logic [NUM_CORES-1:0]       r_resp_valid;
    access_check_result_t       r_resp_result;
    logic                       r_resp_timeout;
    logic                       r_chk_cs;
    logic [CORE_ID_WIDTH-1:0]   r_chk_core_id;
    logic [ADDR_WIDTH-1:0]      r_chk_addr;
    logic                       r_chk_we;
    logic                       r_busy;

    logic [NUM_CORES-1:0]       w_grant_oh;
    logic [CORE_ID_WIDTH-1:0]   w_grant_idx;
    logic                       w_grant_any;
    logic [ADDR_WIDTH-1:0]      w_win_addr;
    logic                       w_win_we;

    rr_picker #(
        .N     (NUM_CORES),
        .IDX_W (CORE_ID_WIDTH)
    ) u_rr_picker (
        .req        (req),
        .last_grant (r_last_grant),
        .grant      (w_grant_oh),
        .grant_idx  (w_grant_idx)
    );

    assign w_grant_any = |w_grant_oh;

    // One-hot AND-OR mux of the winner's address and write enable; avoids
    // indexing req_addr with an id that could exceed NUM_CORES-1.
    always_comb begin
        w_win_addr = '0;
        w_win_we   = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_grant_oh[i]) begin
                w_win_addr = w_win_addr | req_addr[i];
                w_win_we   = w_win_we   | req_we[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ARB_IDLE;
            r_last_grant   <= c_LAST_INIT;
            r_wd_cnt       <= '0;
            r_grant_oh     <= '0;
            r_resp_valid   <= '0;
            r_resp_result  <= ACCESS_DENIED;
            r_resp_timeout <= 1'b0;
            r_chk_cs       <= 1'b0;
            r_chk_core_id  <= '0;
            r_chk_addr     <= '0;
            r_chk_we       <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    // A busy checker blocks all grants, including one still
                    // finishing a check that the watchdog already abandoned.
                    if (w_grant_any && !chk_bsy) begin
                        r_chk_core_id <= w_grant_idx;
                        r_chk_addr    <= w_win_addr;
                        r_chk_we      <= w_win_we;
                        r_grant_oh    <= w_grant_oh;
                        r_last_grant  <= w_grant_idx;
                        r_chk_cs      <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    r_chk_cs <= 1'b0;
                    r_wd_cnt <= '0;
                    r_state  <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (chk_rdy) begin
                        r_resp_result  <= chk_result;
                        r_resp_valid   <= r_grant_oh;
                        r_resp_timeout <= 1'b0;
                        r_state        <= ARB_RESP;
                    end else if (r_wd_cnt == c_WD_LAST) begin
                        r_resp_result  <= ACCESS_DENIED;
                        r_resp_valid   <= r_grant_oh;
                        r_resp_timeout <= 1'b1;
                        r_state        <= ARB_RESP;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
                    end
                end
                ARB_RESP: begin
                    r_resp_valid   <= '0;
                    r_resp_timeout <= 1'b0;
                    r_busy         <= 1'b0;
                    r_state        <= ARB_IDLE;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign resp_valid   = r_resp_valid;
    assign resp_result  = r_resp_result;
    assign resp_timeout = r_resp_timeout;
    assign chk_cs       = r_chk_cs;
    assign chk_core_id  = r_chk_core_id;
    assign chk_addr     = r_chk_addr;
    assign chk_we       = r_chk_we;
    assign busy         = r_busy;

endmodule : mpu_check_arbiter

`default_nettype wire

// File: tb/tb_mpu_check_arbiter.sv
// ============================================================================
// Module      : tb_mpu_check_arbiter
// Description : Directed self-checking bench for mpu_check_arbiter with a
//               small access_check stub (rdy three cycles after chk_cs, busy
//               released two cycles after rdy, latency adjustable).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mpu_check_arbiter;
    import mpu_check_arbiter_pkg::*;

    localparam int c_NC = 4;
    localparam int c_TO = 16;

    logic                              clk = 1'b0;
    logic                              rst;
    logic [c_NC-1:0]                   req;
    logic [c_NC-1:0][ADDR_WIDTH-1:0]   req_addr;
    logic [c_NC-1:0]                   req_we;
    logic [c_NC-1:0]                   resp_valid;
    access_check_result_t              resp_result;
    logic                              resp_timeout;
    logic                              chk_cs;
    logic [CORE_ID_WIDTH-1:0]          chk_core_id;
    logic [ADDR_WIDTH-1:0]             chk_addr;
    logic                              chk_we;
    access_check_result_t              chk_result;
    logic                              chk_rdy;
    logic                              chk_bsy;
    logic                              busy;

    int n_cmp  = 0;
    int n_fail = 0;

    int                   stub_rdy_at = 1;
    access_check_result_t stub_result = ACCESS_GRANTED;
    logic [7:0]           stub_cnt;

    always #5 clk = ~clk;

    mpu_check_arbiter #(
        .NUM_CORES      (c_NC),
        .TIMEOUT_CYCLES (c_TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .resp_valid   (resp_valid),
        .resp_result  (resp_result),
        .resp_timeout (resp_timeout),
        .chk_cs       (chk_cs),
        .chk_core_id  (chk_core_id),
        .chk_addr     (chk_addr),
        .chk_we       (chk_we),
        .chk_result   (chk_result),
        .chk_rdy      (chk_rdy),
        .chk_bsy      (chk_bsy),
        .busy         (busy)
    );

    // access_check stub: busy from the cycle after chk_cs, rdy when the
    // busy counter reaches stub_rdy_at, busy dropped two cycles after that.
    always @(posedge clk) begin
        if (rst) begin
            chk_bsy    <= 1'b0;
            chk_rdy    <= 1'b0;
            stub_cnt   <= '0;
            chk_result <= ACCESS_DENIED;
        end else begin
            chk_rdy <= 1'b0;
            if (chk_cs) begin
                chk_bsy  <= 1'b1;
                stub_cnt <= '0;
            end else if (chk_bsy) begin
                stub_cnt <= stub_cnt + 8'd1;
                if (int'(stub_cnt) == stub_rdy_at) begin
                    chk_rdy    <= 1'b1;
                    chk_result <= stub_result;
                end
                if (int'(stub_cnt) == stub_rdy_at + 2) chk_bsy <= 1'b0;
            end
        end
    end

    // chk_cs must never start a check while the checker is busy.
    always @(negedge clk) begin
        if (rst === 1'b0 && chk_cs === 1'b1) begin
            n_cmp++;
            assert (chk_bsy === 1'b0) else begin
                n_fail++;
                $error("FAIL cs_while_bsy: observed chk_bsy=%b expected 0", chk_bsy);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        req         = '0;
        req_addr    = '0;
        req_we      = '0;
        tick(3);

        // ---- reset values ----
        check("rst_resp_valid", resp_valid, 4'b0000);
        check("rst_resp_result", resp_result, ACCESS_DENIED);
        check("rst_resp_timeout", resp_timeout, 1'b0);
        check("rst_chk_cs", chk_cs, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;

        // ---- single read, core 2 (cycle 0 now) ----
        req[2] = 1'b1; req_addr[2] = 32'h1000; req_we[2] = 1'b0;
        stub_result = ACCESS_GRANTED;
        tick(1); // c1
        check("s1_cs_c1", chk_cs, 1'b1);
        check("s1_core_id", chk_core_id, 2'd2);
        check("s1_addr", chk_addr, 32'h1000);
        check("s1_we", chk_we, 1'b0);
        check("s1_busy", busy, 1'b1);
        tick(1); // c2
        check("s1_cs_c2", chk_cs, 1'b0);
        tick(3); // c5
        check("s1_resp_valid", resp_valid, 4'b0100);
        check("s1_resp_result", resp_result, ACCESS_GRANTED);
        check("s1_resp_timeout", resp_timeout, 1'b0);
        req = '0;
        tick(1); // c6
        check("s1_resp_clear", resp_valid, 4'b0000);
        check("s1_busy_clear", busy, 1'b0);
        tick(2);

        // ---- contention: cores 0 and 2 together after reset ----
        do_reset();
        req = 4'b0101;
        req_addr[0] = 32'h100; req_we[0] = 1'b1;
        req_addr[2] = 32'h200; req_we[2] = 1'b0;
        tick(1); // c1
        check("s2_cs0", chk_cs, 1'b1);
        check("s2_id0", chk_core_id, 2'd0);
        check("s2_we0", chk_we, 1'b1);
        check("s2_addr0", chk_addr, 32'h100);
        tick(4); // c5
        check("s2_resp0", resp_valid, 4'b0001);
        req[0] = 1'b0;
        stub_result = ACCESS_GRANTED_RO;
        tick(1); // c6
        check("s2_cs_c6", chk_cs, 1'b0);
        tick(1); // c7
        check("s2_cs2", chk_cs, 1'b1);
        check("s2_id2", chk_core_id, 2'd2);
        check("s2_addr2", chk_addr, 32'h200);
        tick(4); // c11
        check("s2_resp2", resp_valid, 4'b0100);
        check("s2_result2", resp_result, ACCESS_GRANTED_RO);
        req = '0;
        tick(2);

        // ---- fairness: all four cores hold req for 8 grants ----
        do_reset();
        stub_result = ACCESS_GRANTED;
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick(1); // c 6k+1
            check($sformatf("s3_cs_%0d", k), chk_cs, 1'b1);
            check($sformatf("s3_id_%0d", k), chk_core_id, 64'(k % 4));
            tick(4); // c 6k+5
            check($sformatf("s3_resp_%0d", k), resp_valid, 64'(1 << (k % 4)));
            tick(1);
        end
        req = '0;
        tick(3);

        // ---- timeout, late rdy ignored, next grant waits for bsy ----
        do_reset();
        stub_rdy_at = 30;
        req = 4'b0010; req_addr[1] = 32'h40; req_we[1] = 1'b0;
        tick(1); // c1
        check("s4_cs", chk_cs, 1'b1);
        check("s4_id", chk_core_id, 2'd1);
        tick(16); // c17
        check("s4_no_resp_c17", resp_valid, 4'b0000);
        check("s4_busy_c17", busy, 1'b1);
        tick(1); // c18
        check("s4_resp_valid", resp_valid, 4'b0010);
        check("s4_resp_result", resp_result, ACCESS_DENIED);
        check("s4_resp_timeout", resp_timeout, 1'b1);
        req = 4'b1000; req_addr[3] = 32'h80; req_we[3] = 1'b1;
        tick(1); // c19
        check("s4_resp_clear", resp_valid, 4'b0000);
        check("s4_timeout_clear", resp_timeout, 1'b0);
        check("s4_idle", busy, 1'b0);
        tick(15); // c34, late rdy was in c33
        check("s4_late_rdy_ignored", resp_valid, 4'b0000);
        check("s4_blocked_c34", chk_cs, 1'b0);
        tick(1); // c35
        check("s4_blocked_c35", chk_cs, 1'b0);
        stub_rdy_at = 1;
        tick(1); // c36
        check("s4_next_cs", chk_cs, 1'b1);
        check("s4_next_id", chk_core_id, 2'd3);
        check("s4_next_addr", chk_addr, 32'h80);
        tick(4); // c40
        check("s4_next_resp", resp_valid, 4'b1000);
        check("s4_next_timeout", resp_timeout, 1'b0);
        check("s4_next_result", resp_result, ACCESS_GRANTED);
        req = '0;
        tick(2);

        // ---- address stability after grant ----
        do_reset();
        req = 4'b0010; req_addr[1] = 32'h2000; req_we[1] = 1'b1;
        tick(1); // c1
        check("s5_addr_c1", chk_addr, 32'h2000);
        tick(1); // c2
        req_addr[1] = 32'h3000; req_we[1] = 1'b0;
        tick(1); // c3
        check("s5_addr_c3", chk_addr, 32'h2000);
        check("s5_we_c3", chk_we, 1'b1);
        tick(2); // c5
        check("s5_resp", resp_valid, 4'b0010);
        check("s5_addr_resp", chk_addr, 32'h2000);
        req = '0;
        tick(2);

        // ---- reset mid-WAIT ----
        do_reset();
        req = 4'b0010; req_addr[1] = 32'h500; req_we[1] = 1'b1;
        tick(1); // c1
        check("s6_cs", chk_cs, 1'b1);
        tick(2); // c3
        rst = 1'b1;
        tick(1); // c4
        check("s6_rst_busy", busy, 1'b0);
        check("s6_rst_core_id", chk_core_id, 2'd0);
        check("s6_rst_addr", chk_addr, 32'h0);
        check("s6_rst_we", chk_we, 1'b0);
        check("s6_rst_cs", chk_cs, 1'b0);
        check("s6_rst_resp_valid", resp_valid, 4'b0000);
        check("s6_rst_result", resp_result, ACCESS_DENIED);
        rst = 1'b0;
        req = 4'b1000; req_addr[3] = 32'h600; req_we[3] = 1'b0;
        tick(1); // c5 (c1 of new request)
        check("s6_new_cs", chk_cs, 1'b1);
        check("s6_new_id", chk_core_id, 2'd3);
        check("s6_new_addr", chk_addr, 32'h600);
        tick(4); // c9
        check("s6_new_resp", resp_valid, 4'b1000);
        check("s6_new_result", resp_result, ACCESS_GRANTED);
        req = '0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule : tb_mpu_check_arbiter

`default_nettype wire
